// File: rtl/count_sequencer.sv
// count_sequencer: run/pause/load controller for the 4-bit display counter.
// Holds the programmable rate divider and sequences q under four count modes.
module count_sequencer #(
  parameter int TICK_BASE = 50000000,
  parameter int DIV_W     = 28
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       load_req,
  input  logic [3:0] load_val,
  input  logic [1:0] freq,
  input  logic [1:0] mode,
  output logic [3:0] q,
  output logic       tick,
  output logic       done,
  output logic [1:0] state,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [DIV_W-1:0] R1 = DIV_W'(TICK_BASE - 1);
  localparam logic [DIV_W-1:0] R2 = DIV_W'(2 * TICK_BASE - 1);
  localparam logic [DIV_W-1:0] R4 = DIV_W'(4 * TICK_BASE - 1);

  state_t           r_state;
  logic [3:0]       r_q;
  logic             r_tick;
  logic             r_done;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_cur_freq;
  logic [1:0]       r_cur_mode;
  logic             r_dir;

  logic [DIV_W-1:0] w_reload;
  logic             w_due;
  logic [3:0]       w_nq;
  logic             w_ev_done;
  logic             w_halt;
  logic             w_dir_nxt;

  // Reload value for the currently selected rate; full speed reloads to 0.
  always_comb begin
    w_reload = '0;
    case (freq)
      2'b01:   w_reload = R1;
      2'b10:   w_reload = R2;
      2'b11:   w_reload = R4;
      default: w_reload = '0;
    endcase
  end

  // A count event is due when running at full speed or the divider reached 0.
  assign w_due = (r_cur_freq == 2'b00) || (r_div == '0);

  // Next count value and side effects for one advance under the latched mode.
  always_comb begin
    w_nq      = r_q;
    w_ev_done = 1'b0;
    w_halt    = 1'b0;
    w_dir_nxt = r_dir;
    case (r_cur_mode)
      2'b00: begin
        w_nq      = r_q + 4'd1;
        w_ev_done = (r_q == 4'd15);
      end
      2'b01: begin
        w_nq      = r_q - 4'd1;
        w_ev_done = (r_q == 4'd0);
      end
      2'b10: begin
        w_nq      = r_q + 4'd1;
        w_halt    = (r_q == 4'd14);
        w_ev_done = (r_q == 4'd14);
      end
      default: begin
        if (r_dir == DIR_UP) begin
          w_nq = r_q + 4'd1;
          if (r_q == 4'd14) w_dir_nxt = DIR_DOWN;
        end else begin
          w_nq = r_q - 4'd1;
          if (r_q == 4'd1) begin
            w_dir_nxt = DIR_UP;
            w_ev_done = 1'b1;
          end
        end
      end
    endcase
  end

  // Control FSM: reset > load > stop > start > count event; outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_q        <= 4'd0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_div      <= '0;
      r_cur_freq <= 2'b00;
      r_cur_mode <= 2'b00;
      r_dir      <= DIR_UP;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      if (load_req) begin
        r_q        <= load_val;
        r_div      <= w_reload;
        r_cur_freq <= freq;
        r_dir      <= DIR_UP;
        if (r_state == S_HALT) r_state <= S_IDLE;
      end else if (stop) begin
        // Divider and count freeze; a due event stays pending at div_cnt=0.
        if (r_state == S_RUN) r_state <= S_PAUSE;
      end else if (start && r_state == S_IDLE) begin
        r_state    <= S_RUN;
        r_cur_mode <= mode;
        r_cur_freq <= freq;
        r_div      <= w_reload;
        r_dir      <= DIR_UP;
      end else if (start && r_state == S_PAUSE) begin
        r_state <= S_RUN;
      end else if (r_state == S_RUN) begin
        if (w_due) begin
          r_q        <= w_nq;
          r_div      <= w_reload;
          r_cur_freq <= freq;
          r_dir      <= w_dir_nxt;
          r_tick     <= 1'b1;
          r_done     <= w_ev_done;
          if (w_halt) r_state <= S_HALT;
        end else begin
          r_div <= r_div - 1'b1;
        end
      end
    end
  end

  assign q     = r_q;
  assign tick  = r_tick;
  assign done  = r_done;
  assign state = r_state;
  assign busy  = (r_state == S_RUN);

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer with TICK_BASE=4.
module tb_count_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       load_req = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [1:0] freq = 2'b00;
  logic [1:0] mode = 2'b00;
  logic [3:0] q;
  logic       tick;
  logic       done;
  logic [1:0] state;
  logic       busy;

  count_sequencer #(.TICK_BASE(4), .DIV_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .load_req(load_req), .load_val(load_val), .freq(freq), .mode(mode),
    .q(q), .tick(tick), .done(done), .state(state), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] q;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   tick_q[$];
  int   cyc = 0;
  int   last_tick = 0;
  int   tests = 0;
  int   fails = 0;
  int   s_cyc = 0;
  int   p_cyc = 0;
  bit   mon_en = 1'b0;
  exp_t e;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every tick pops one expected (q, done) pair.
  always @(negedge clock) begin
    if (mon_en) begin
      if (tick === 1'b1) begin
        tick_q.push_back(cyc);
        last_tick = cyc;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_tick at cyc %0d: q=%0d done=%0d", cyc, q, done);
        end else begin
          e = exp_q.pop_front();
          if (q !== e.q || done !== e.done) begin
            fails++;
            $display("FAIL sb_tick at cyc %0d: got q=%0d done=%0d, want q=%0d done=%0d",
                     cyc, q, done, e.q, e.done);
          end
        end
      end else if (done !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL done_without_tick at cyc %0d: done=%b", cyc, done);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int qv, input bit dv);
    exp_t x;
    x.q = 4'(qv);
    x.done = dv;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] f, input logic [1:0] m);
    freq = f;
    mode = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    load_val = v;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    mon_en = 1'b1;
    chk("rst_q", q, 0);
    chk("rst_state", state, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);

    // Wrap-up at freq 01: one tick every 4 cycles, done on 15->0
    for (int i = 1; i < 16; i++) push(i, 1'b0);
    push(0, 1'b1);
    tick_q.delete();
    do_start(2'b01, 2'b00);
    s_cyc = cyc;
    repeat (64) step();
    chk("wrap_busy", busy, 1);
    chk("wrap_state", state, 1);
    do_stop();
    chk("wrap_ticks", tick_q.size(), 16);
    if (tick_q.size() >= 2) begin
      chk("wrap_first_lat", tick_q[0] - s_cyc, 4);
      chk("wrap_period", tick_q[1] - tick_q[0], 4);
    end
    chk("wrap_pause_state", state, 2);
    chk("wrap_drain", exp_q.size(), 0);

    // One-shot-up from 13 at full speed, then halt
    do_reset();
    do_load(4'd13);
    chk("os_load_q", q, 13);
    chk("os_load_state", state, 0);
    push(14, 1'b0);
    push(15, 1'b1);
    do_start(2'b00, 2'b10);
    repeat (2) step();
    chk("os_halt_state", state, 3);
    chk("os_halt_q", q, 15);
    do_start(2'b00, 2'b10);
    repeat (2) step();
    chk("os_start_ignored", state, 3);
    do_load(4'd0);
    chk("os_reload_state", state, 0);
    chk("os_reload_q", q, 0);
    chk("os_drain", exp_q.size(), 0);

    // Bounce: 30 events per done, direction back to up afterwards
    for (int i = 1; i < 16; i++) push(i, 1'b0);
    for (int i = 14; i > 0; i--) push(i, 1'b0);
    push(0, 1'b1);
    do_start(2'b00, 2'b11);
    repeat (30) step();
    do_stop();
    chk("bnc_q_end", q, 0);
    chk("bnc_drain", exp_q.size(), 0);
    push(1, 1'b0);
    do_start(2'b00, 2'b00);
    step();
    do_stop();
    chk("bnc_dir_up", q, 1);
    chk("bnc_drain2", exp_q.size(), 0);

    // Pause keeps the remaining period
    do_reset();
    push(1, 1'b0);
    do_start(2'b01, 2'b00);
    repeat (6) step();
    do_stop();
    repeat (10) step();
    chk("pause_q", q, 1);
    chk("pause_state", state, 2);
    push(2, 1'b0);
    do_start(2'b01, 2'b11);
    p_cyc = cyc;
    repeat (2) step();
    do_stop();
    chk("resume_lat", last_tick - p_cyc, 2);
    chk("resume_drain", exp_q.size(), 0);

    // Rate change mid-period applies only at the next reload
    do_reset();
    for (int i = 1; i < 5; i++) push(i, 1'b0);
    tick_q.delete();
    do_start(2'b01, 2'b00);
    s_cyc = cyc;
    repeat (5) step();
    freq = 2'b11;
    repeat (35) step();
    do_stop();
    chk("frq_ticks", tick_q.size(), 4);
    if (tick_q.size() == 4) begin
      chk("frq_p0", tick_q[0] - s_cyc, 4);
      chk("frq_p1", tick_q[1] - tick_q[0], 4);
      chk("frq_p2", tick_q[2] - tick_q[1], 16);
      chk("frq_p3", tick_q[3] - tick_q[2], 16);
    end
    chk("frq_drain", exp_q.size(), 0);

    // Load on an event edge wins; RUN continues from the loaded value
    do_reset();
    push(1, 1'b0);
    push(2, 1'b0);
    push(10, 1'b0);
    do_start(2'b00, 2'b00);
    repeat (2) step();
    do_load(4'd9);
    chk("ld_q", q, 9);
    chk("ld_tick", tick, 0);
    chk("ld_state", state, 1);
    step();
    do_stop();
    chk("ld_drain", exp_q.size(), 0);

    // Reset mid-run
    do_reset();
    push(1, 1'b0);
    push(2, 1'b0);
    do_start(2'b00, 2'b00);
    repeat (2) step();
    do_reset();
    chk("mrst_q", q, 0);
    chk("mrst_state", state, 0);
    chk("mrst_tick", tick, 0);
    chk("mrst_done", done, 0);
    step();
    chk("mrst_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Run/pause/load controller for the 4-bit display counter datapath.
- Contains the programmable rate divider (1, 0.5 or 0.25 Hz, or full speed).
- Sequences the count value under one of four count modes and exposes the current count for the seven-segment decoder.
- Sits between the board switches/keys and the hex decoder, replacing ad-hoc enable wiring with an explicit state machine.

Parameters:
TICK_BASE, 50000000, clock cycles per 1 Hz period; reload value R = TICK_BASE*k - 1, where k = 1/2/4 for freq 01/10/11
DIV_W, 28, divider width; must hold 4*TICK_BASE - 1

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  command pulse: begin or resume counting
stop  input  1  command pulse: pause counting
load_req  input  1  command pulse: parallel-load load_val into count
load_val  input  4  value loaded on load_req
freq  input  2  rate select: 00 every cycle, 01 R=TICK_BASE-1, 10 R=2*TICK_BASE-1, 11 R=4*TICK_BASE-1
mode  input  2  00 wrap-up, 01 wrap-down, 10 one-shot-up, 11 bounce
q  output  4  current count (registered)
tick  output  1  one-cycle strobe, high in the cycle q shows a newly advanced value
done  output  1  one-cycle strobe on terminal event (defined below)
state  output  2  IDLE=00, RUN=01, PAUSE=10, HALT=11
busy  output  1  state==RUN (combinational from state register)

Behaviour:
- Reset (sync, reset=1 at a clock edge) overrides everything. Result: q=0, state=IDLE, tick=0, done=0, div_cnt=0, cur_freq=00, cur_mode=00, dir=up.
- Commands are sampled every edge. Priority: reset > load_req > stop > start > count event.
- load_req, any state:
  - q<=load_val; div_cnt<=R(freq); cur_freq<=freq; dir<=up; tick=0, done=0 that edge.
  - State HALT->IDLE; every other state is unchanged, so RUN keeps running from the loaded value.
- start:
  - IDLE->RUN: latches cur_mode<=mode, cur_freq<=freq, div_cnt<=R(freq), dir<=up.
  - PAUSE->RUN: div_cnt and cur_mode are retained.
  - Ignored in RUN and HALT.
- stop: RUN->PAUSE; div_cnt and q are frozen. Ignored elsewhere.
- Count event e = (state==RUN) and no load_req/stop this edge and (cur_freq==00 or div_cnt==0).
  - On e: q advances per cur_mode, div_cnt<=R(freq), cur_freq<=freq, tick<=1.
  - Otherwise in RUN with cur_freq!=00: div_cnt decrements, tick<=0.
  - Event period in steady RUN is R+1 cycles. A freq change takes effect only at the next reload; the current period is never truncated.
- Advance rules:
  - 00: q+1, 15->0 with done<=1.
  - 01: q-1, 0->15 with done<=1.
  - 10: q+1. When q becomes 15: done<=1 and state<=HALT; no further events.
  - 11: dir=up gives q+1; q becomes 15 sets dir<=down. dir=down gives q-1; q becomes 0 sets dir<=up and done<=1.
- done is otherwise 0. tick and done never assert outside RUN except the HALT-entry edge, which is an event edge.
- mode changes while not in IDLE are ignored until the next IDLE->RUN start.
- Stop on the same edge as a would-be event: the event is suppressed and div_cnt is held at 0. On resume, the first RUN cycle produces the event.
- Divider arithmetic is unsigned DIV_W bits. Decrement occurs only when div_cnt!=0, so the divider never underflows.
- Mid-run reset returns all registers to their reset values on that edge; no tick or done is emitted.

Test Plan (TICK_BASE=4):
- Reset, then start with freq=01, mode=00 -> tick every 4 cycles. q goes 0,1,2,…,15,0. done is high only on the edge q=0 after 15. busy=1.
- Mode 10 from load_val=13 (load_req, then start, freq=00) -> q=14, 15 on consecutive cycles. done=1 and state=HALT together with q=15. Further start is ignored. A subsequent load_req with load_val=0 gives state=IDLE, q=0.
- Mode 11, freq=00, start from 0 -> q goes up to 15 then down 14…0. done pulses once at q=0, direction then returns to up. Total 30 events per done.
- freq=01 RUN, stop two cycles after a tick, wait 10 cycles, start -> q unchanged during PAUSE. The next tick arrives 2 cycles after resume, so the remaining period is preserved.
- freq changed 01->11 mid-period -> the current period still ends at 4 cycles. The following periods are 16 cycles.
- load_req (load_val=9) on the same edge as an event, and separately reset mid-RUN -> q=9 with tick=0 and the state stays RUN. For the reset case: q=0, state=IDLE, tick=done=0 on the next cycle.
